// File: rtl/regfile_access_scheduler.sv
// Arbitrates one dual-operand read and two writebacks onto a banked register file.
// Read response has 1-cycle latency in a one-entry slot; a stalled slot blocks new reads.
module regfile_access_scheduler #(
  parameter int NUM_LANES    = 16,
  parameter int NUM_REGS     = 64,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int NUM_WARPS    = 8,
  parameter int WARP_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [WARP_W-1:0]           rd_req_warp,
  input  logic [ADDR_W-1:0]           rd_req_addr0,
  input  logic [ADDR_W-1:0]           rd_req_addr1,
  input  logic [NUM_LANES-1:0]        rd_req_mask,

  output logic                        rd_rsp_valid,
  input  logic                        rd_rsp_ready,
  output logic [NUM_LANES*DATA_W-1:0] rd_rsp_data0,
  output logic [NUM_LANES*DATA_W-1:0] rd_rsp_data1,
  output logic [NUM_LANES-1:0]        rd_rsp_mask,

  input  logic                        wb0_valid,
  output logic                        wb0_ready,
  input  logic [WARP_W-1:0]           wb0_warp,
  input  logic [ADDR_W-1:0]           wb0_addr,
  input  logic [NUM_LANES-1:0]        wb0_mask,
  input  logic [NUM_LANES*DATA_W-1:0] wb0_data,

  input  logic                        wb1_valid,
  output logic                        wb1_ready,
  input  logic [WARP_W-1:0]           wb1_warp,
  input  logic [ADDR_W-1:0]           wb1_addr,
  input  logic [NUM_LANES-1:0]        wb1_mask,
  input  logic [NUM_LANES*DATA_W-1:0] wb1_data,

  output logic [WARP_W-1:0]           rf_warp_selector,
  output logic [NUM_LANES-1:0]        rf_read_en_0,
  output logic [NUM_LANES-1:0]        rf_read_en_1,
  output logic [ADDR_W-1:0]           rf_raddr_0,
  output logic [ADDR_W-1:0]           rf_raddr_1,
  output logic [NUM_LANES-1:0]        rf_write_en,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [NUM_LANES*DATA_W-1:0] rf_wdata,
  input  logic [NUM_LANES*DATA_W-1:0] rf_rdata_0,
  input  logic [NUM_LANES*DATA_W-1:0] rf_rdata_1
);

  localparam int LW    = NUM_LANES * DATA_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  if (NUM_REGS > (1 << ADDR_W) || NUM_WARPS > (1 << WARP_W)) begin : g_cfg_check
    $error("regfile_access_scheduler: ADDR_W or WARP_W too narrow for NUM_REGS/NUM_WARPS");
  end

  typedef struct packed {
    logic [WARP_W-1:0]    warp;
    logic [ADDR_W-1:0]    addr;
    logic [NUM_LANES-1:0] mask;
    logic [LW-1:0]        data;
  } wb_req_t;

  wb_req_t              wb0_req, wb1_req, w_sel;
  logic                 w_vld, w_src;
  logic                 r_elig, compat, starved;
  logic                 wr_gnt, rd_gnt;

  logic                 rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic [WARP_W-1:0]    warp_sel_q, warp_sel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [LW-1:0]        rsp_data0_q, rsp_data0_d;
  logic [LW-1:0]        rsp_data1_q, rsp_data1_d;
  logic [NUM_LANES-1:0] rsp_mask_q, rsp_mask_d;
  logic [LW-1:0]        rdata0_masked, rdata1_masked;

  assign wb0_req = '{warp: wb0_warp, addr: wb0_addr, mask: wb0_mask, data: wb0_data};
  assign wb1_req = '{warp: wb1_warp, addr: wb1_addr, mask: wb1_mask, data: wb1_data};

  // Writeback candidate: the lone valid source, or the round-robin choice when both are valid.
  always_comb begin
    w_vld = wb0_valid || wb1_valid;
    w_src = (wb0_valid && wb1_valid) ? rr_ptr_q : wb1_valid;
    w_sel = w_src ? wb1_req : wb0_req;
  end

  assign r_elig  = rd_req_valid && (!rsp_valid_q || rd_rsp_ready);
  assign compat  = (w_sel.warp == rd_req_warp) &&
                   (rd_req_addr0 != w_sel.addr) && (rd_req_addr1 != w_sel.addr);
  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  // Co-issue needs a shared warp and no address overlap; otherwise writes win until the read starves.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (rst_n) begin
      if (w_vld && r_elig) begin
        if (compat) begin
          wr_gnt = 1'b1;
          rd_gnt = 1'b1;
        end else if (starved) begin
          rd_gnt = 1'b1;
        end else begin
          wr_gnt = 1'b1;
        end
      end else begin
        wr_gnt = w_vld;
        rd_gnt = r_elig;
      end
    end
  end

  always_comb begin
    wb0_ready    = wr_gnt && !w_src;
    wb1_ready    = wr_gnt &&  w_src;
    rd_req_ready = rd_gnt;

    rf_write_en  = wr_gnt ? w_sel.mask : '0;
    rf_waddr     = wr_gnt ? w_sel.addr : '0;
    rf_wdata     = wr_gnt ? w_sel.data : '0;
    rf_read_en_0 = rd_gnt ? rd_req_mask : '0;
    rf_read_en_1 = rd_gnt ? rd_req_mask : '0;
    rf_raddr_0   = rd_gnt ? rd_req_addr0 : '0;
    rf_raddr_1   = rd_gnt ? rd_req_addr1 : '0;

    if (wr_gnt) begin
      warp_sel_d = w_sel.warp;
    end else if (rd_gnt) begin
      warp_sel_d = rd_req_warp;
    end else begin
      warp_sel_d = warp_sel_q;
    end
    rf_warp_selector = warp_sel_d;
  end

  always_comb begin
    rdata0_masked = '0;
    rdata1_masked = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_req_mask[i]) begin
        rdata0_masked[DATA_W*i +: DATA_W] = rf_rdata_0[DATA_W*i +: DATA_W];
        rdata1_masked[DATA_W*i +: DATA_W] = rf_rdata_1[DATA_W*i +: DATA_W];
      end
    end
  end

  // Only a blocked-but-eligible read ages the starvation counter; any read grant resets it.
  always_comb begin
    rr_ptr_d = wr_gnt ? !w_src : rr_ptr_q;
    starve_d = starve_q;
    if (rd_gnt) begin
      starve_d = '0;
    end else if (wr_gnt && r_elig && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    rsp_mask_d  = rsp_mask_q;
    if (rd_gnt) begin
      rsp_valid_d = 1'b1;
      rsp_data0_d = rdata0_masked;
      rsp_data1_d = rdata1_masked;
      rsp_mask_d  = rd_req_mask;
    end else if (rd_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= 1'b0;
      starve_q    <= '0;
      warp_sel_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      rsp_mask_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      starve_q    <= starve_d;
      warp_sel_q  <= warp_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
      rsp_mask_q  <= rsp_mask_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data0 = rsp_data0_q;
  assign rd_rsp_data1 = rsp_data1_q;
  assign rd_rsp_mask  = rsp_mask_q;

endmodule
